// File: rtl/banked_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : banked_regfile_if
// Purpose  : Decode-side bus of the banked register file: mode selection,
//            read-port addresses and registered read data, and the Lo/Hi
//            write ports.
// Revision : 1.0 - initial release
// ============================================================================
interface banked_regfile_if #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3
);
    logic [4:0]               mode;
    logic                     user_bank;
    logic                     rd_en;
    logic [4*NUM_RD-1:0]      rd_addr;
    logic [DATA_W*NUM_RD-1:0] rd_data;
    logic                     wr_en;
    logic [3:0]               wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wrhi_en;
    logic [3:0]               wrhi_addr;
    logic [DATA_W-1:0]        wrhi_data;

    // Decode stage: drives addresses, mode and write ports, receives read data
    modport master (
        output mode, user_bank, rd_en, rd_addr,
        output wr_en, wr_addr, wr_data, wrhi_en, wrhi_addr, wrhi_data,
        input  rd_data
    );

    // Register file side
    modport slave (
        input  mode, user_bank, rd_en, rd_addr,
        input  wr_en, wr_addr, wr_data, wrhi_en, wrhi_addr, wrhi_data,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/banked_regfile.sv
`default_nettype none
// ============================================================================
// Module   : banked_regfile
// Purpose  : ARM7TDMI banked register file, 31 physical registers, NUM_RD
//            registered read ports, Lo/Hi write ports (Hi wins on conflict),
//            optional same-cycle write-to-read bypass, user-bank override
//            and read-enable hold. Asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module banked_regfile #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    banked_regfile_if.slave bus
);

    localparam logic [4:0] c_MODE_USR = 5'b10000;
    localparam logic [4:0] c_MODE_FIQ = 5'b10001;
    localparam logic [4:0] c_MODE_IRQ = 5'b10010;
    localparam logic [4:0] c_MODE_SVC = 5'b10011;
    localparam logic [4:0] c_MODE_ABT = 5'b10111;
    localparam logic [4:0] c_MODE_UND = 5'b11011;
    localparam int         c_NUM_PHYS = 31;

    // Logical-to-physical mapping shared by every port. SYS and any
    // unlisted encoding fall through to the user bank, as does user_bank=1.
    function automatic logic [4:0] f_map(
        input logic [4:0] mode,
        input logic       user_bank,
        input logic [3:0] addr
    );
        logic [4:0] eff;
        logic [4:0] phys;
        eff  = user_bank ? c_MODE_USR : mode;
        phys = {1'b0, addr};
        case (eff)
            c_MODE_FIQ: begin
                if ((addr >= 4'd8) && (addr <= 4'd14)) phys = {1'b0, addr} + 5'd8;
            end
            c_MODE_SVC: begin
                if (addr == 4'd13)      phys = 5'd23;
                else if (addr == 4'd14) phys = 5'd24;
            end
            c_MODE_ABT: begin
                if (addr == 4'd13)      phys = 5'd25;
                else if (addr == 4'd14) phys = 5'd26;
            end
            c_MODE_IRQ: begin
                if (addr == 4'd13)      phys = 5'd27;
                else if (addr == 4'd14) phys = 5'd28;
            end
            c_MODE_UND: begin
                if (addr == 4'd13)      phys = 5'd29;
                else if (addr == 4'd14) phys = 5'd30;
            end
            default: ;
        endcase
        return phys;
    endfunction

    logic [DATA_W-1:0] r_regs [c_NUM_PHYS];
    logic [4:0]        w_wr_idx;
    logic [4:0]        w_wrhi_idx;

    assign w_wr_idx   = f_map(bus.mode, bus.user_bank, bus.wr_addr);
    assign w_wrhi_idx = f_map(bus.mode, bus.user_bank, bus.wrhi_addr);

    // Storage update; Hi is assigned last so it overrides Lo on a shared index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_PHYS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (bus.wr_en) begin
                r_regs[w_wr_idx] <= bus.wr_data;
            end
            if (bus.wrhi_en) begin
                r_regs[w_wrhi_idx] <= bus.wrhi_data;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [4:0]        w_idx;
            logic [DATA_W-1:0] w_next;
            logic [DATA_W-1:0] r_data;

            assign w_idx = f_map(bus.mode, bus.user_bank, bus.rd_addr[4*k +: 4]);

            // Stored value, optionally replaced by this cycle's write (Hi first)
            always_comb begin
                w_next = r_regs[w_idx];
                if (BYPASS != 0) begin
                    if (bus.wrhi_en && (w_wrhi_idx == w_idx)) begin
                        w_next = bus.wrhi_data;
                    end else if (bus.wr_en && (w_wr_idx == w_idx)) begin
                        w_next = bus.wr_data;
                    end
                end
            end

            // Read capture; rd_en=0 freezes the port
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (bus.rd_en) begin
                    r_data <= w_next;
                end
            end

            assign bus.rd_data[DATA_W*k +: DATA_W] = r_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_banked_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_regfile
// Purpose  : Self-checking bench; a BYPASS=1 and a BYPASS=0 instance share
//            the same stimulus, compared against a reference model and
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_regfile;

    localparam logic [4:0] USR = 5'b10000;
    localparam logic [4:0] FIQ = 5'b10001;
    localparam logic [4:0] IRQ = 5'b10010;
    localparam logic [4:0] SVC = 5'b10011;
    localparam logic [4:0] ABT = 5'b10111;
    localparam logic [4:0] UND = 5'b11011;
    localparam logic [4:0] SYS = 5'b11111;

    typedef struct {
        logic [4:0]  mode;
        logic        ub;
        logic        ren;
        logic [3:0]  ra0, ra1, ra2;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        he;
        logic [3:0]  ha;
        logic [31:0] hd;
        logic        chk;
        logic [31:0] eb;   // hand-computed port 0, BYPASS=1
        logic [31:0] en;   // hand-computed port 0, BYPASS=0
    } vec_t;

    typedef struct packed {
        logic [95:0] b;
        logic [95:0] n;
    } exp_t;

    logic clk;
    logic rst_n;

    banked_regfile_if #(.DATA_W(32), .NUM_RD(3)) bus_b ();
    banked_regfile_if #(.DATA_W(32), .NUM_RD(3)) bus_n ();

    banked_regfile #(.DATA_W(32), .NUM_RD(3), .BYPASS(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    banked_regfile #(.DATA_W(32), .NUM_RD(3), .BYPASS(0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_regs [31];
    logic [31:0] prev_b [3];
    logic [31:0] prev_n [3];
    exp_t        q [$];
    vec_t        vecs [33];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference mapping: bank base + offset
    function automatic logic [4:0] tb_map(input logic [4:0] mode, input logic ub,
                                          input logic [3:0] a);
        logic [4:0] m;
        int         base;
        m = ub ? USR : mode;
        if (a == 4'd15) return 5'd15;
        if (m == FIQ) return (a >= 4'd8) ? 5'(16 + int'(a) - 8) : {1'b0, a};
        case (m)
            SVC:     base = 23;
            ABT:     base = 25;
            IRQ:     base = 27;
            UND:     base = 29;
            default: base = -1;
        endcase
        if (base >= 0 && a >= 4'd13) return 5'(base + int'(a) - 13);
        return {1'b0, a};
    endfunction

    function automatic vec_t mk(input logic [4:0] mode, input logic ub, input logic ren,
                                input logic [3:0] ra0, input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic he, input logic [3:0] ha, input logic [31:0] hd,
                                input logic chk_en, input logic [31:0] eb, input logic [31:0] en);
        vec_t v;
        v.mode = mode; v.ub = ub; v.ren = ren;
        v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
        v.we = we; v.wa = wa; v.wd = wd;
        v.he = he; v.ha = ha; v.hd = hd;
        v.chk = chk_en; v.eb = eb; v.en = en;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus_b.mode = v.mode;  bus_n.mode = v.mode;
        bus_b.user_bank = v.ub; bus_n.user_bank = v.ub;
        bus_b.rd_en = v.ren;  bus_n.rd_en = v.ren;
        bus_b.rd_addr = {v.ra2, v.ra1, v.ra0}; bus_n.rd_addr = {v.ra2, v.ra1, v.ra0};
        bus_b.wr_en = v.we;   bus_n.wr_en = v.we;
        bus_b.wr_addr = v.wa; bus_n.wr_addr = v.wa;
        bus_b.wr_data = v.wd; bus_n.wr_data = v.wd;
        bus_b.wrhi_en = v.he;   bus_n.wrhi_en = v.he;
        bus_b.wrhi_addr = v.ha; bus_n.wrhi_addr = v.ha;
        bus_b.wrhi_data = v.hd; bus_n.wrhi_data = v.hd;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 31; i++) m_regs[i] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            prev_b[k] = 32'h0;
            prev_n[k] = 32'h0;
        end
        q.delete();
    endtask

    // One cycle: drive, predict and enqueue, clock, dequeue and compare
    task automatic step(input vec_t v, input string tag);
        exp_t       e;
        logic [3:0] ra [3];
        logic [4:0] idx, wi, hi;
        logic [31:0] st, bv;
        drive(v);
        ra[0] = v.ra0; ra[1] = v.ra1; ra[2] = v.ra2;
        wi = tb_map(v.mode, v.ub, v.wa);
        hi = tb_map(v.mode, v.ub, v.ha);
        for (int k = 0; k < 3; k++) begin
            idx = tb_map(v.mode, v.ub, ra[k]);
            st  = m_regs[idx];
            bv  = st;
            if (v.he && hi == idx)      bv = v.hd;
            else if (v.we && wi == idx) bv = v.wd;
            if (v.ren) begin
                prev_b[k] = bv;
                prev_n[k] = st;
            end
            e.b[32*k +: 32] = prev_b[k];
            e.n[32*k +: 32] = prev_n[k];
        end
        if (v.we) m_regs[wi] = v.wd;
        if (v.he) m_regs[hi] = v.hd;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s byp p%0d", tag, k), bus_b.rd_data[32*k +: 32], e.b[32*k +: 32]);
            chk($sformatf("%s nobyp p%0d", tag, k), bus_n.rd_data[32*k +: 32], e.n[32*k +: 32]);
        end
        if (v.chk) begin
            chk($sformatf("%s hand byp", tag), bus_b.rd_data[31:0], v.eb);
            chk($sformatf("%s hand nobyp", tag), bus_n.rd_data[31:0], v.en);
        end
    endtask

    vec_t idle;

    initial begin
        // FIQ banking
        vecs[0]  = mk(USR,0,1, 8,14,15, 1,8,32'h11, 0,0,0, 1,32'h11,32'h0);
        vecs[1]  = mk(FIQ,0,1, 8,14,15, 1,8,32'h22, 0,0,0, 1,32'h22,32'h0);
        vecs[2]  = mk(USR,0,1, 8,14,15, 0,0,0,      0,0,0, 1,32'h11,32'h11);
        vecs[3]  = mk(FIQ,0,1, 8,14,15, 0,0,0,      0,0,0, 1,32'h22,32'h22);
        vecs[4]  = mk(SVC,0,1, 8,14,15, 0,0,0,      0,0,0, 1,32'h11,32'h11);
        // r13 via Lo, r14 via Hi in each mode
        vecs[5]  = mk(USR,0,1, 13,14,15, 1,13,32'h1013, 1,14,32'h1014, 1,32'h1013,32'h0);
        vecs[6]  = mk(FIQ,0,1, 14,13,15, 1,13,32'h2013, 1,14,32'h2014, 1,32'h2014,32'h0);
        vecs[7]  = mk(SVC,0,1, 13,14,15, 1,13,32'h3013, 1,14,32'h3014, 1,32'h3013,32'h0);
        vecs[8]  = mk(ABT,0,1, 13,14,15, 1,13,32'h4013, 1,14,32'h4014, 1,32'h4013,32'h0);
        vecs[9]  = mk(IRQ,0,1, 14,13,15, 1,13,32'h5013, 1,14,32'h5014, 1,32'h5014,32'h0);
        vecs[10] = mk(UND,0,1, 13,14,15, 1,13,32'h6013, 1,14,32'h6014, 1,32'h6013,32'h0);
        vecs[11] = mk(USR,0,1, 13,14,8, 0,0,0, 0,0,0, 1,32'h1013,32'h1013);
        vecs[12] = mk(FIQ,0,1, 14,13,8, 0,0,0, 0,0,0, 1,32'h2014,32'h2014);
        vecs[13] = mk(SVC,0,1, 13,14,8, 0,0,0, 0,0,0, 1,32'h3013,32'h3013);
        vecs[14] = mk(ABT,0,1, 14,13,8, 0,0,0, 0,0,0, 1,32'h4014,32'h4014);
        vecs[15] = mk(IRQ,0,1, 13,14,8, 0,0,0, 0,0,0, 1,32'h5013,32'h5013);
        vecs[16] = mk(UND,0,1, 14,13,8, 0,0,0, 0,0,0, 1,32'h6014,32'h6014);
        vecs[17] = mk(SYS,0,1, 13,14,8, 0,0,0, 0,0,0, 1,32'h1013,32'h1013);
        // r15 is shared by all modes
        vecs[18] = mk(IRQ,0,1, 15,13,14, 1,15,32'hF15, 0,0,0, 1,32'hF15,32'h0);
        vecs[19] = mk(FIQ,0,1, 15,13,14, 0,0,0,       0,0,0, 1,32'hF15,32'hF15);
        // Lo/Hi conflict in SVC with same-cycle read
        vecs[20] = mk(SVC,0,1, 13,14,15, 1,13,32'hA, 1,13,32'hB, 1,32'hB,32'h3013);
        vecs[21] = mk(SVC,0,1, 13,14,15, 0,0,0,      0,0,0,      1,32'hB,32'hB);
        // user_bank override in IRQ
        vecs[22] = mk(IRQ,1,1, 14,13,15, 1,14,32'h55, 0,0,0, 1,32'h55,32'h1014);
        vecs[23] = mk(IRQ,0,1, 14,13,15, 0,0,0,       0,0,0, 1,32'h5014,32'h5014);
        vecs[24] = mk(USR,0,1, 14,13,15, 0,0,0,       0,0,0, 1,32'h55,32'h55);
        // Unlisted mode encodings act as USER
        vecs[25] = mk(5'b00000,0,1, 13,14,15, 1,13,32'h77, 0,0,0, 1,32'h77,32'h1013);
        vecs[26] = mk(USR,0,1,      13,14,15, 0,0,0,       0,0,0, 1,32'h77,32'h77);
        vecs[27] = mk(5'b10110,0,1, 13,14,15, 0,0,0,       0,0,0, 1,32'h77,32'h77);
        // Read hold while r0 is written
        vecs[28] = mk(USR,0,1, 0,14,15,  0,0,0,        0,0,0, 1,32'h0,32'h0);
        vecs[29] = mk(USR,0,0, 13,8,15,  1,0,32'h100,  0,0,0, 1,32'h0,32'h0);
        vecs[30] = mk(USR,0,0, 13,8,15,  1,0,32'h101,  0,0,0, 1,32'h0,32'h0);
        vecs[31] = mk(USR,0,0, 13,8,15,  1,0,32'h102,  0,0,0, 1,32'h0,32'h0);
        vecs[32] = mk(USR,0,1, 0,14,15,  0,0,0,        0,0,0, 1,32'h102,32'h102);

        idle = mk(USR,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
        drive(idle);
        model_reset();

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset byp p%0d", k), bus_b.rd_data[32*k +: 32], 32'h0);
            chk($sformatf("reset nobyp p%0d", k), bus_n.rd_data[32*k +: 32], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous clear between edges, then a write lost under reset
        step(mk(USR,0,1, 3,3,3, 1,3,32'hDEADBEEF, 0,0,0, 1,32'hDEADBEEF,32'h0), "clr_wr");
        step(mk(USR,0,1, 3,3,3, 0,0,0,            0,0,0, 1,32'hDEADBEEF,32'hDEADBEEF), "clr_rd");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_clr byp p%0d", k), bus_b.rd_data[32*k +: 32], 32'h0);
            chk($sformatf("async_clr nobyp p%0d", k), bus_n.rd_data[32*k +: 32], 32'h0);
        end
        model_reset();
        drive(mk(USR,0,1, 3,3,3, 1,3,32'h1234, 0,0,0, 0,0,0));
        @(posedge clk);
        #1;
        chk("rst_hold byp", bus_b.rd_data[31:0], 32'h0);
        chk("rst_hold nobyp", bus_n.rd_data[31:0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(USR,0,1, 3,8,13, 0,0,0, 0,0,0, 1,32'h0,32'h0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
